// File: rtl/mmio_console_pkg.sv
// mmio_console_pkg: register offsets, STATUS/CTRL bit positions and output FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mmio_console_pkg;

   // Word offsets inside the register window (dataadr[3:0])
   localparam logic [3:0] OFF_DATA   = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_CTRL   = 4'h8;

   // STATUS layout: {.., overflow, irq_en, full, empty, count[3:0]}
   localparam int STAT_COUNT_LSB = 0;
   localparam int STAT_COUNT_W   = 4;
   localparam int STAT_EMPTY     = 4;
   localparam int STAT_FULL      = 5;
   localparam int STAT_IRQ_EN    = 6;
   localparam int STAT_OVERFLOW  = 7;

   // CTRL layout
   localparam int CTRL_IRQ_EN = 0;
   localparam int CTRL_FLUSH  = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_HOLDOFF = 2'd2
   } tx_state_e;

endpackage

// File: rtl/mmio_console_fifo.sv
// console_fifo: byte FIFO with push/pop/flush, occupancy count and full/empty flags.
// Latency: a push is visible at the head one edge later; head_dat is read combinationally.
// Backpressure: none internally -- the caller only pushes when not full (or with a same-cycle pop).
// Ports: clk, reset (async active-low), push/push_dat, pop, flush, head_dat,
//        count (0..DEPTH), count_nxt (occupancy after this edge), full, empty.
module console_fifo #(
   parameter  int DEPTH = 8,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [7:0]    push_dat,
   input  logic          pop,
   input  logic          flush,
   output logic [7:0]    head_dat,
   output logic [CW-1:0] count,
   output logic [CW-1:0] count_nxt,
   output logic          full,
   output logic          empty
);

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // Flush dominates any push/pop presented in the same cycle.
   assign count_nxt = flush ? '0 : (count + CW'(push) - CW'(pop));
   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign head_dat  = mem[rd_ptr];

   // Pointers are exactly log2(DEPTH) bits so they wrap modulo DEPTH for free.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count_nxt;
      end
   end

endmodule

// File: rtl/mmio_console.sv
// mmio_console: memory-mapped console; CPU stores bytes to DATA, an output FSM streams them with a forced idle gap.
// Latency: a store presented before edge k is queued at edge k and drives tx_valid after edge k+1; hit/readdata are combinational.
// Backpressure: tx_valid/tx_data hold until tx_ready; stores to a full FIFO without a same-cycle pop are dropped and set overflow.
// Ports: clk, reset (async active-low); CPU side memwrite/dataadr/writedata -> readdata/hit;
//        stream side tx_data/tx_valid with tx_ready; irq = irq_en & (empty | overflow), registered.
module mmio_console
   import mmio_console_pkg::*;
#(
   parameter int           n     = 32,
   parameter int           DEPTH = 8,
   parameter int           GAP   = 2,
   parameter logic [n-1:0] BASE  = 32'h0000FF00
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         memwrite,
   input  logic [n-1:0] dataadr,
   input  logic [n-1:0] writedata,
   output logic [n-1:0] readdata,
   output logic         hit,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic         irq
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   logic [3:0]    offset;
   logic          in_window;
   logic          data_wr;
   logic          ctrl_wr;
   logic          flush;
   logic          push;
   logic          pop;
   logic [7:0]    head_dat;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          full;
   logic          empty;
   logic          overflow;
   logic          overflow_nxt;
   logic          irq_en;
   logic          irq_en_nxt;
   tx_state_e     state;
   tx_state_e     state_nxt;
   logic [GW-1:0] hold_cnt;
   logic [GW-1:0] hold_nxt;
   logic          unused_wdat;

   assign unused_wdat = ^writedata[n-1:8];

   // ---------------- register decode ----------------
   assign offset    = dataadr[3:0];
   assign in_window = (dataadr[n-1:4] == BASE[n-1:4]);
   assign hit       = in_window &
                      ((offset == OFF_DATA) | (offset == OFF_STATUS) | (offset == OFF_CTRL));
   assign data_wr   = memwrite & hit & (offset == OFF_DATA);
   assign ctrl_wr   = memwrite & hit & (offset == OFF_CTRL);
   assign flush     = ctrl_wr & writedata[CTRL_FLUSH];

   // A full FIFO still accepts a store when the head leaves in the same cycle.
   assign pop  = (state == ST_PRESENT) & tx_ready;
   assign push = data_wr & (~full | pop) & ~flush;

   always_comb begin
      readdata = '0;
      if (in_window) begin
         case (offset)
            OFF_STATUS: begin
               readdata[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(count);
               readdata[STAT_EMPTY]    = empty;
               readdata[STAT_FULL]     = full;
               readdata[STAT_IRQ_EN]   = irq_en;
               readdata[STAT_OVERFLOW] = overflow;
            end
            OFF_CTRL: readdata[CTRL_IRQ_EN] = irq_en;
            default: ;
         endcase
      end
   end

   // ---------------- storage ----------------
   console_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_dat  (writedata[7:0]),
      .pop       (pop),
      .flush     (flush),
      .head_dat  (head_dat),
      .count     (count),
      .count_nxt (count_nxt),
      .full      (full),
      .empty     (empty)
   );

   // ---------------- control / status registers ----------------
   assign irq_en_nxt   = ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en;
   assign overflow_nxt = flush ? 1'b0 : ((data_wr & full & ~pop) ? 1'b1 : overflow);

   // irq is built from the post-edge state so it agrees with STATUS in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_en   <= 1'b0;
         overflow <= 1'b0;
         irq      <= 1'b0;
      end else begin
         irq_en   <= irq_en_nxt;
         overflow <= overflow_nxt;
         irq      <= irq_en_nxt & ((count_nxt == '0) | overflow_nxt);
      end
   end

   // ---------------- output FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // HOLDOFF is entered with GAP-1 loaded and leaves when the counter reads 0,
   // giving exactly GAP cycles in HOLDOFF.
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      case (state)
         ST_IDLE: begin
            if (!empty) state_nxt = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (tx_ready) begin
               if (GAP == 0) begin
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_HOLDOFF;
                  hold_nxt  = GW'(GAP - 1);
               end
            end
         end
         ST_HOLDOFF: begin
            if (hold_cnt == '0) state_nxt = ST_IDLE;
            else                hold_nxt  = hold_cnt - GW'(1);
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (flush) begin
         state_nxt = ST_IDLE;
         hold_nxt  = '0;
      end
   end

   assign tx_valid = (state == ST_PRESENT);
   assign tx_data  = tx_valid ? head_dat : 8'h00;

endmodule

// File: tb/tb_mmio_console.sv
// tb_mmio_console: directed and randomized checks of mmio_console against a queue-based model.
// Latency: n/a.
// Backpressure: tx_ready driven by the bench (fixed and random).
module tb_mmio_console;

   localparam int          N     = 32;
   localparam int          DEPTH = 8;
   localparam int          GAP   = 2;
   localparam logic [31:0] BASE  = 32'h0000FF00;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        memwrite  = 1'b0;
   logic [31:0] dataadr   = 32'h0;
   logic [31:0] writedata = 32'h0;
   logic        tx_ready  = 1'b0;
   logic [31:0] readdata;
   logic        hit;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        irq;

   mmio_console #(.n(N), .DEPTH(DEPTH), .GAP(GAP), .BASE(BASE)) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .dataadr   (dataadr),
      .writedata (writedata),
      .readdata  (readdata),
      .hit       (hit),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [7:0] exp_q[$];
   logic [7:0] out_q[$];
   logic [7:0] in_q[$];
   int         hs_cyc[$];
   logic       m_ovf    = 1'b0;
   logic       m_irq_en = 1'b0;
   logic       m_irq    = 1'b0;
   logic [7:0] last_pop = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // STATUS as described by the register map, from the model state.
   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s      = 32'h0;
      s[3:0] = 4'(exp_q.size());
      s[4]   = (exp_q.size() == 0);
      s[5]   = (exp_q.size() == DEPTH);
      s[6]   = m_irq_en;
      s[7]   = m_ovf;
      return s;
   endfunction

   // One clock: score a handshake, apply the bus write to the model, advance, check irq.
   task automatic cycle();
      logic hs;
      hs = tx_valid & tx_ready;
      if (hs) begin
         chk("hs_model_nonempty", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            chk("tx_data_order", 32'(tx_data), 32'(exp_q[0]));
            last_pop = exp_q.pop_front();
            out_q.push_back(tx_data);
            hs_cyc.push_back(cyc);
         end
      end
      if (memwrite && dataadr == BASE + 32'h8) begin
         m_irq_en = writedata[0];
         if (writedata[1]) begin
            exp_q.delete();
            m_ovf = 1'b0;
         end
      end else if (memwrite && dataadr == BASE) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(writedata[7:0]);
         else                      m_ovf = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
      m_irq = m_irq_en & ((exp_q.size() == 0) | m_ovf);
      chk("irq", 32'(irq), 32'(m_irq));
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      memwrite  = 1'b1;
      dataadr   = a;
      writedata = d;
      cycle();
      memwrite  = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      dataadr = a;
      #1;
      d = readdata;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) cycle();
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [31:0] exp_rd;
      int          sent;

      // ---- reset state ----
      #1 reset = 1'b0;
      #1;
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data",  32'(tx_data),  32'd0);
      chk("rst_irq",      32'(irq),      32'd0);
      @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      rd(BASE + 32'h4, d);
      chk("rst_status", d, 32'h10);

      // ---- address decode over the whole window and outside it ----
      for (int o = 0; o < 16; o++) begin
         rd(BASE + 32'(o), d);
         chk("hit_window", 32'(hit), 32'((o == 0) || (o == 4) || (o == 8)));
         exp_rd = (o == 4) ? m_status() : (o == 8) ? 32'(m_irq_en) : 32'h0;
         chk("readdata_window", d, exp_rd);
         cycle();
      end
      rd(BASE + 32'h14, d);
      chk("hit_outside_hi", 32'(hit), 32'd0);
      chk("rd_outside_hi", d, 32'h0);
      rd(32'h0000EF04, d);
      chk("hit_outside_lo", 32'(hit), 32'd0);
      cycle();

      // ---- first byte latency ----
      tx_ready = 1'b1;
      store(BASE, 32'h96);
      chk("lat_edge1_valid", 32'(tx_valid), 32'd0);
      cycle();
      chk("lat_edge2_valid", 32'(tx_valid), 32'd1);
      chk("lat_edge2_data",  32'(tx_data),  32'h96);
      cycle();
      rd(BASE + 32'h4, d);
      chk("first_status", d, 32'h10);
      repeat (4) cycle();

      // ---- fill past full, hold, then drain with fixed spacing ----
      tx_ready = 1'b0;
      for (int i = 1; i <= 9; i++) store(BASE, 32'(i));
      rd(BASE + 32'h4, d);
      chk("full_status_model", d, m_status());
      chk("full_status", d, 32'hA8);
      for (int i = 0; i < 3; i++) begin
         chk("hold_valid", 32'(tx_valid), 32'd1);
         chk("hold_data",  32'(tx_data),  32'h01);
         cycle();
      end
      tx_ready = 1'b1;
      hs_cyc.delete();
      out_q.delete();
      drain("drain_full");
      chk("drain_full_count", 32'(out_q.size()), 32'd8);
      for (int i = 0; i < out_q.size(); i++) chk("drain_full_order", 32'(out_q[i]), 32'(i + 1));
      for (int i = 1; i < hs_cyc.size(); i++)
         chk("hs_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(GAP + 2));
      rd(BASE + 32'h4, d);
      chk("sticky_ovf_status", d, 32'h90);

      // ---- store into a full FIFO during the handshake cycle ----
      repeat (4) cycle();
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) store(BASE, 32'h11 + 32'(i));
      chk("full_present", 32'(tx_valid), 32'd1);
      tx_ready = 1'b1;
      out_q.delete();
      store(BASE, 32'hAA);
      rd(BASE + 32'h4, d);
      chk("pushpop_status_model", d, m_status());
      chk("pushpop_status", d, 32'hA8);
      drain("drain_pushpop");
      chk("pushpop_count", 32'(out_q.size()), 32'd9);
      chk("pushpop_last", 32'(last_pop), 32'hAA);

      // ---- flush with bytes queued, irq behaviour ----
      repeat (4) cycle();
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) store(BASE, 32'h31 + 32'(i));
      cycle();
      rd(BASE + 32'h4, d);
      chk("preflush_status", d, 32'h83);
      chk("preflush_valid", 32'(tx_valid), 32'd1);
      store(BASE + 32'h8, 32'h3);
      chk("flush_valid", 32'(tx_valid), 32'd0);
      chk("flush_irq", 32'(irq), 32'd1);
      rd(BASE + 32'h4, d);
      chk("flush_status", d, 32'h50);
      rd(BASE + 32'h8, d);
      chk("ctrl_readback_on", d, 32'h1);
      store(BASE, 32'h44);
      chk("irq_busy", 32'(irq), 32'd0);
      tx_ready = 1'b1;
      drain("drain_irq");
      repeat (3) cycle();
      chk("irq_idle", 32'(irq), 32'd1);
      store(BASE + 32'h8, 32'h0);
      chk("irq_disabled", 32'(irq), 32'd0);
      rd(BASE + 32'h8, d);
      chk("ctrl_readback_off", d, 32'h0);

      // ---- reset in the middle of a presented byte ----
      repeat (4) cycle();
      tx_ready = 1'b0;
      store(BASE, 32'h5A);
      cycle();
      chk("prerst_valid", 32'(tx_valid), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("midrst_valid", 32'(tx_valid), 32'd0);
      chk("midrst_data",  32'(tx_data),  32'd0);
      chk("midrst_irq",   32'(irq),      32'd0);
      exp_q.delete();
      m_ovf    = 1'b0;
      m_irq_en = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      rd(BASE + 32'h4, d);
      chk("postrst_status", d, 32'h10);
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("postrst_no_byte", 32'(tx_valid), 32'd0);
      end

      // ---- random traffic with random backpressure ----
      in_q.delete();
      out_q.delete();
      sent = 0;
      for (int c = 0; c < 3000 && !(sent == 20 && exp_q.size() == 0); c++) begin
         tx_ready = 1'($urandom_range(0, 1));
         if (sent < 20 && exp_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
            memwrite  = 1'b1;
            dataadr   = BASE;
            writedata = $urandom();
            in_q.push_back(writedata[7:0]);
            sent++;
         end else begin
            memwrite = 1'b0;
         end
         cycle();
      end
      memwrite = 1'b0;
      chk("rand_sent", 32'(sent), 32'd20);
      chk("rand_received", 32'(out_q.size()), 32'd20);
      for (int i = 0; i < in_q.size() && i < out_q.size(); i++)
         chk("rand_sequence", 32'(out_q[i]), 32'(in_q[i]));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
